mem_stage: RTL
==============

Name: mem_stage

Overview:
Memory stage directly downstream of EX. It holds the EX/MEM pipeline register, performs word loads and stores over a req/ready data-memory bus with variable latency and a timeout, and holds the MEM/WB pipeline register. It also drives the ex_mem and mem_wb forwarding data back into EX, and stalls upstream stages while a memory access is outstanding.

Parameters:
WORD_BITWIDTH, 32, data/address width
REG_NUM_BITWIDTH, 5, destination register index width
TIMEOUT_CYCLES, 16, max cycles dmem_req may stay unacknowledged before abort (>=1)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
ex_valid  input  1  EX holds a real instruction (0 = bubble)
ex_ALUresult  input  WORD_BITWIDTH  EX ALU result; address for loads/stores
ex_storeData  input  WORD_BITWIDTH  forwarded rs2 value for stores
ex_rd  input  REG_NUM_BITWIDTH  destination register
ex_regWrite  input  1  instruction writes rd
ex_memRead  input  1  load
ex_memWrite  input  1  store
ex_memToReg  input  1  WB data selects load data
flush  input  1  capture a bubble instead of EX contents
stall  output  1  upstream must hold (combinational)
fd_ex_mem_data  output  WORD_BITWIDTH  EX/MEM ALU result, to EX forwarding mux
ex_mem_rd  output  REG_NUM_BITWIDTH  EX/MEM rd, for the hazard unit
ex_mem_regWrite  output  1  EX/MEM valid & regWrite, for the hazard unit
dmem_req  output  1  access request
dmem_we  output  1  1 = store
dmem_addr  output  WORD_BITWIDTH  word-aligned address
dmem_wdata  output  WORD_BITWIDTH  store data
dmem_ready  input  1  access completes in this cycle
dmem_rdata  input  WORD_BITWIDTH  load data, valid when dmem_ready
wb_valid  output  1  MEM/WB holds a completed instruction
wb_rd  output  REG_NUM_BITWIDTH  WB destination
wb_regWrite  output  1  write regfile this cycle
fd_mem_wb_data  output  WORD_BITWIDTH  WB write data, to regfile and EX forwarding
misaligned  output  1  one-cycle pulse: access dropped, addr[1:0]!=0
bus_error  output  1  one-cycle pulse: access aborted on timeout

Behaviour:
- Reset: all pipeline registers zero, FSM IDLE, timeout counter 0. All outputs 0.
- EX/MEM capture on each edge with stall=0. Captures EX fields, with valid = ex_valid & ~flush. When stall=1 it holds and flush is ignored; the hazard unit must re-assert flush.
- A memory op is an EX/MEM entry with valid & (memRead|memWrite).
- Misaligned memory op (addr[1:0]!=0): no request is issued. The entry completes in 1 cycle with wb_regWrite forced 0, and misaligned pulses in the cycle the entry reaches WB.
- FSM IDLE/ACCESS:
  - dmem_req = (state IDLE with an aligned mem op in EX/MEM) or state ACCESS. It is driven only from registers.
  - dmem_addr = {addr[31:2],2'b00}, dmem_we = memWrite, dmem_wdata = storeData. These stay stable while dmem_req=1.
  - req & ready at an edge: complete, go to IDLE, clear the counter.
  - req & ~ready: go to / stay in ACCESS and increment the counter.
  - Counter reaching TIMEOUT_CYCLES with no ready: abort, complete with wb_regWrite=0, bus_error pulse, go to IDLE.
- stall = dmem_req & ~dmem_ready & ~timeout_abort. A zero-wait memory causes no stall.
- Completion: a non-mem or bubble entry completes in its one EX/MEM cycle. A mem op completes on ready or abort.
- MEM/WB capture at the completing edge:
  - wb_valid=1.
  - wb_data = memToReg ? dmem_rdata (latched at ready) : ALUresult.
  - wb_regWrite = regWrite & ~memWrite & ~fault.
- If no completion occurs at an edge, MEM/WB loads a bubble: wb_valid=0, wb_regWrite=0, data held.
- Latency: non-mem instructions appear at WB 2 edges after leaving EX. A load adds one cycle per unacknowledged req cycle.
- Reset asserted mid-access: the access is abandoned immediately, with no completion and no pulse.

Decomposition:
- Shared package: INST_* opcode constants, WORD_BITWIDTH, REG_NUM_BITWIDTH, the FSM state encoding, and an EX/MEM field bundle typedef.
- One sub-module, dmem_if: the req/ready FSM plus timeout counter. It outputs done, fault and latched rdata.

Test Plan:
- ADD result 0x0000_0010, rd=5, regWrite=1 -> fd_ex_mem_data=0x10 one cycle later; wb_regWrite=1, wb_rd=5, fd_mem_wb_data=0x10 after the next edge; stall never 1.
- Load addr 0x100, ready tied 1, rdata=0xCAFEBABE -> dmem_req for 1 cycle with dmem_addr=0x100; stall=0; wb data=0xCAFEBABE.
- Load with ready after 3 wait cycles -> stall=1 for exactly 3 cycles; EX/MEM holds; dmem_addr stable; WB gets rdata on the 4th cycle.
- Store addr 0x204, data 0x12345678, ready at first cycle -> dmem_we=1, wdata=0x12345678, wb_regWrite=0.
- Store to 0x202 -> no dmem_req, misaligned pulses once, wb_regWrite=0. Load with ready held 0 and TIMEOUT_CYCLES=4 -> stall for 4 cycles, then bus_error pulse, stall=0, wb_regWrite=0.
- flush=1 with a valid EX ALU op -> bubble (ex_mem_regWrite=0, wb_valid=0). rst_n low during ACCESS -> dmem_req=0 and all outputs 0 immediately.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: widths, opcodes, FSM encoding and
// the EX/MEM pipeline register bundle.
package mem_stage_pkg;

  localparam int unsigned WORD_BITWIDTH    = 32;
  localparam int unsigned REG_NUM_BITWIDTH = 5;

  localparam logic [6:0] INST_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_STORE  = 7'b0100011;
  localparam logic [6:0] INST_OP     = 7'b0110011;
  localparam logic [6:0] INST_OP_IMM = 7'b0010011;

  typedef enum logic {
    MEM_IDLE   = 1'b0,
    MEM_ACCESS = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic                        valid;
    logic [WORD_BITWIDTH-1:0]    alu_result;
    logic [WORD_BITWIDTH-1:0]    store_data;
    logic [REG_NUM_BITWIDTH-1:0] rd;
    logic                        reg_write;
    logic                        mem_read;
    logic                        mem_write;
    logic                        mem_to_reg;
  } ex_mem_t;

endpackage

// File: rtl/mem_stage_dmem_if.sv
// Data-memory req/ready handshake with timeout; reports completion, fault
// and the returned load data for the MEM/WB register.
module dmem_if #(
  parameter int unsigned WORD_BITWIDTH  = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     op,
  input  logic                     dmem_ready,
  input  logic [WORD_BITWIDTH-1:0] dmem_rdata,
  output logic                     dmem_req,
  output logic                     done,
  output logic                     fault,
  output logic [WORD_BITWIDTH-1:0] rdata
);
  import mem_stage_pkg::*;

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  mem_state_e       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             timeout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= MEM_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    dmem_req = (state == MEM_IDLE && op) || (state == MEM_ACCESS);
    // cnt counts unacknowledged request cycles; a late ready still wins
    timeout  = dmem_req && !dmem_ready && (cnt == CNT_W'(TIMEOUT_CYCLES));
    done     = (dmem_req && dmem_ready) || timeout;
    fault    = timeout;
    rdata    = dmem_rdata;
    if (done) begin
      state_nx = MEM_IDLE;
      cnt_nx   = '0;
    end else if (dmem_req) begin
      state_nx = MEM_ACCESS;
      cnt_nx   = cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: EX/MEM register, word load/store over the data-memory
// bus, MEM/WB register, forwarding outputs and upstream stall.
module mem_stage #(
  parameter int unsigned WORD_BITWIDTH    = 32,
  parameter int unsigned REG_NUM_BITWIDTH = 5,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ex_valid,
  input  logic [WORD_BITWIDTH-1:0]    ex_ALUresult,
  input  logic [WORD_BITWIDTH-1:0]    ex_storeData,
  input  logic [REG_NUM_BITWIDTH-1:0] ex_rd,
  input  logic                        ex_regWrite,
  input  logic                        ex_memRead,
  input  logic                        ex_memWrite,
  input  logic                        ex_memToReg,
  input  logic                        flush,
  output logic                        stall,
  output logic [WORD_BITWIDTH-1:0]    fd_ex_mem_data,
  output logic [REG_NUM_BITWIDTH-1:0] ex_mem_rd,
  output logic                        ex_mem_regWrite,
  output logic                        dmem_req,
  output logic                        dmem_we,
  output logic [WORD_BITWIDTH-1:0]    dmem_addr,
  output logic [WORD_BITWIDTH-1:0]    dmem_wdata,
  input  logic                        dmem_ready,
  input  logic [WORD_BITWIDTH-1:0]    dmem_rdata,
  output logic                        wb_valid,
  output logic [REG_NUM_BITWIDTH-1:0] wb_rd,
  output logic                        wb_regWrite,
  output logic [WORD_BITWIDTH-1:0]    fd_mem_wb_data,
  output logic                        misaligned,
  output logic                        bus_error
);
  import mem_stage_pkg::*;

  ex_mem_t                  em;
  logic                     mem_op, mis_op, aligned_op;
  logic                     done, fault;
  logic [WORD_BITWIDTH-1:0] rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      em <= '0;
    end else if (!stall) begin
      em.valid      <= ex_valid & ~flush;
      em.alu_result <= ex_ALUresult;
      em.store_data <= ex_storeData;
      em.rd         <= ex_rd;
      em.reg_write  <= ex_regWrite;
      em.mem_read   <= ex_memRead;
      em.mem_write  <= ex_memWrite;
      em.mem_to_reg <= ex_memToReg;
    end
  end

  always_comb begin
    mem_op     = em.valid & (em.mem_read | em.mem_write);
    mis_op     = mem_op & (em.alu_result[1:0] != 2'b00);
    aligned_op = mem_op & ~mis_op;
  end

  dmem_if #(
    .WORD_BITWIDTH (WORD_BITWIDTH),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_dmem_if (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (aligned_op),
    .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .dmem_req  (dmem_req),
    .done      (done),
    .fault     (fault),
    .rdata     (rdata)
  );

  always_comb begin
    stall           = dmem_req & ~dmem_ready & ~fault;
    fd_ex_mem_data  = em.alu_result;
    ex_mem_rd       = em.rd;
    ex_mem_regWrite = em.valid & em.reg_write;
    dmem_we         = em.mem_write;
    dmem_addr       = {em.alu_result[WORD_BITWIDTH-1:2], 2'b00};
    dmem_wdata      = em.store_data;
  end

  // Every unstalled edge retires the EX/MEM entry; only a valid one yields a
  // WB slot, anything else becomes a bubble with data held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_regWrite    <= 1'b0;
      fd_mem_wb_data <= '0;
      misaligned     <= 1'b0;
      bus_error      <= 1'b0;
    end else begin
      wb_valid    <= 1'b0;
      wb_regWrite <= 1'b0;
      misaligned  <= 1'b0;
      bus_error   <= 1'b0;
      if (!stall && em.valid) begin
        wb_valid       <= 1'b1;
        wb_rd          <= em.rd;
        wb_regWrite    <= em.reg_write & ~em.mem_write & ~(mis_op | fault);
        fd_mem_wb_data <= em.mem_to_reg ? rdata : em.alu_result;
        misaligned     <= mis_op;
        bus_error      <= fault;
      end
    end
  end

  logic unused_done;
  assign unused_done = done;

endmodule
